// File: rtl/sram_test_result_logger.sv
// Error-record FIFO and per-run statistics for the SRAM tester.
// Mismatches queue for a valid/ready debug reader; counters saturate.
module sram_test_result_logger #(
    parameter int ADDR_BITS = 20,
    parameter int DATA_BITS = 16,
    parameter int DEPTH     = 8,
    parameter int CNT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 test_done,
    input  logic                 test_pass,
    input  logic                 err_valid,
    input  logic [ADDR_BITS-1:0] err_addr,
    input  logic [DATA_BITS-1:0] err_expected,
    input  logic [DATA_BITS-1:0] err_actual,
    input  logic [2:0]           err_pattern,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_expected,
    output logic [DATA_BITS-1:0] rd_actual,
    output logic [2:0]           rd_pattern,
    output logic [CNT_BITS-1:0]  round_count,
    output logic [CNT_BITS-1:0]  fail_rounds,
    output logic [CNT_BITS-1:0]  err_count,
    output logic                 overflow,
    output logic [1:0]           status
);

    localparam int PW = $clog2(DEPTH);
    localparam int RW = 3 + ADDR_BITS + 2 * DATA_BITS;
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PASSING = 2'd1,
        S_FAILED  = 2'd2
    } state_t;

    logic [RW-1:0]       r_mem [DEPTH];
    logic [PW:0]         r_wr_ptr;
    logic [PW:0]         r_rd_ptr;
    logic [RW-1:0]       r_head;
    logic [CNT_BITS-1:0] r_round_cnt;
    logic [CNT_BITS-1:0] r_fail_cnt;
    logic [CNT_BITS-1:0] r_err_cnt;
    logic                r_overflow;
    logic                r_round_err;
    state_t              r_state;
    state_t              w_state_nxt;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_round_fail;
    logic [PW:0]   w_occ;
    logic [PW-1:0] w_rd_nxt_idx;
    logic [RW-1:0] w_rec;
    logic [RW-1:0] w_next_head;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_occ   = r_wr_ptr - r_rd_ptr;
    assign w_pop   = !w_empty && rd_ready;
    assign w_push  = err_valid && (!w_full || w_pop);
    assign w_rec   = {err_pattern, err_addr, err_expected, err_actual};
    assign w_round_fail = r_round_err || err_valid || !test_pass;

    // With one entry left, the successor is the record being pushed now.
    assign w_rd_nxt_idx = r_rd_ptr[PW-1:0] + PW'(1);
    assign w_next_head  = (w_occ == (PW+1)'(1)) ? w_rec
                                                : r_mem[w_rd_nxt_idx];

    always_ff @(posedge clk) begin
        if (w_push && !clear) begin
            r_mem[r_wr_ptr[PW-1:0]] <= w_rec;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_head   <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
            if (w_push && w_empty) begin
                r_head <= w_rec;
            end else if (w_pop && (w_occ != (PW+1)'(1) || w_push)) begin
                r_head <= w_next_head;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_round_cnt <= '0;
            r_fail_cnt  <= '0;
            r_err_cnt   <= '0;
            r_overflow  <= 1'b0;
            r_round_err <= 1'b0;
        end else if (clear) begin
            r_round_cnt <= '0;
            r_fail_cnt  <= '0;
            r_err_cnt   <= '0;
            r_overflow  <= 1'b0;
            r_round_err <= 1'b0;
        end else begin
            if (err_valid && r_err_cnt != CNT_MAX)
                r_err_cnt <= r_err_cnt + 1'b1;
            if (err_valid && w_full && !w_pop)
                r_overflow <= 1'b1;
            if (test_done) begin
                r_round_err <= 1'b0;
                if (r_round_cnt != CNT_MAX)
                    r_round_cnt <= r_round_cnt + 1'b1;
                if (w_round_fail && r_fail_cnt != CNT_MAX)
                    r_fail_cnt <= r_fail_cnt + 1'b1;
            end else if (err_valid) begin
                r_round_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_IDLE;
        end else if (test_done) begin
            if (w_round_fail)          w_state_nxt = S_FAILED;
            else if (r_state == S_IDLE) w_state_nxt = S_PASSING;
        end
    end

    assign rd_valid    = !w_empty;
    assign {rd_pattern, rd_addr, rd_expected, rd_actual} = r_head;
    assign round_count = r_round_cnt;
    assign fail_rounds = r_fail_cnt;
    assign err_count   = r_err_cnt;
    assign overflow    = r_overflow;
    assign status      = r_state;

endmodule

// File: tb/tb_sram_test_result_logger.sv
// Bench for sram_test_result_logger: directed scenarios plus a random
// run, all checked against a queue-based model of the logger.
module tb_sram_test_result_logger;

    localparam int AB   = 20;
    localparam int DB   = 16;
    localparam int DEP  = 8;
    localparam int CB   = 4;
    localparam int CMAX = 15;

    typedef struct packed {
        logic [2:0]    p;
        logic [AB-1:0] a;
        logic [DB-1:0] e;
        logic [DB-1:0] x;
    } rec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          clear = 1'b0;
    logic          test_done = 1'b0;
    logic          test_pass = 1'b0;
    logic          err_valid = 1'b0;
    logic [AB-1:0] err_addr = '0;
    logic [DB-1:0] err_expected = '0;
    logic [DB-1:0] err_actual = '0;
    logic [2:0]    err_pattern = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [AB-1:0] rd_addr;
    logic [DB-1:0] rd_expected;
    logic [DB-1:0] rd_actual;
    logic [2:0]    rd_pattern;
    logic [CB-1:0] round_count;
    logic [CB-1:0] fail_rounds;
    logic [CB-1:0] err_count;
    logic          overflow;
    logic [1:0]    status;

    sram_test_result_logger #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .DEPTH(DEP), .CNT_BITS(CB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .test_done(test_done), .test_pass(test_pass),
        .err_valid(err_valid), .err_addr(err_addr),
        .err_expected(err_expected), .err_actual(err_actual),
        .err_pattern(err_pattern), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_expected(rd_expected), .rd_actual(rd_actual),
        .rd_pattern(rd_pattern), .round_count(round_count),
        .fail_rounds(fail_rounds), .err_count(err_count),
        .overflow(overflow), .status(status)
    );

    always #5 clk = ~clk;

    rec_t mq[$];
    int   m_round, m_fail, m_err, m_st;
    bit   m_ovf, m_rerr;
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    function automatic rec_t head_act();
        rec_t r;
        r = {rd_pattern, rd_addr, rd_expected, rd_actual};
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_round = 0; m_fail = 0; m_err = 0; m_st = 0;
        m_ovf = 1'b0; m_rerr = 1'b0;
    endtask

    // Drive one cycle of inputs and advance the model across the edge.
    task automatic drive_cycle(input bit ev, input logic [AB-1:0] addr,
                               input bit rr, input bit td,
                               input bit tp, input bit clr);
        rec_t r;
        bit   pop_m;
        bit   full_m;
        r.p = 3'($urandom);
        r.a = addr;
        r.e = 16'($urandom);
        r.x = 16'($urandom);
        err_valid = ev; err_addr = r.a; err_expected = r.e;
        err_actual = r.x; err_pattern = r.p;
        rd_ready = rr; test_done = td; test_pass = tp; clear = clr;
        pop_m  = (mq.size() > 0) && rr;
        full_m = (mq.size() == DEP);
        @(posedge clk);
        #1;
        if (clr) begin
            model_reset();
        end else begin
            if (pop_m) void'(mq.pop_front());
            if (ev) begin
                m_err = sat(m_err);
                if (!full_m || pop_m) mq.push_back(r);
                else m_ovf = 1'b1;
            end
            if (td) begin
                m_round = sat(m_round);
                if (m_rerr || ev || !tp) begin
                    m_fail = sat(m_fail);
                    m_st = 2;
                end else if (m_st == 0) begin
                    m_st = 1;
                end
                m_rerr = 1'b0;
            end else if (ev) begin
                m_rerr = 1'b1;
            end
        end
        err_valid = 1'b0; rd_ready = 1'b0;
        test_done = 1'b0; clear = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_rd_valid got %0b want 0", rd_valid);
        end
        n_checks++;
        if (head_act() !== '0) begin
            n_fail++; $display("FAIL reset_fields got %h want 0", head_act());
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if ({round_count, fail_rounds, err_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_counters got %h/%h/%h want 0",
                     round_count, fail_rounds, err_count);
        end
        n_checks++;
        if (overflow !== 1'b0 || status !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_status got ovf=%0b st=%0d want 0/0",
                     overflow, status);
        end
    endtask

    task automatic test_fifo_order();
        logic [AB-1:0] exp_a;
        drive_cycle(0, '0, 0, 0, 0, 1);
        for (int i = 1; i <= 3; i++) drive_cycle(1, AB'(i * 16), 0, 0, 0, 0);
        n_checks++;
        if (rd_valid !== 1'b1 || rd_addr !== 20'h00010) begin
            n_fail++;
            $display("FAIL order_first got v=%0b a=%h want 1/00010",
                     rd_valid, rd_addr);
        end
        for (int i = 1; i <= 3; i++) begin
            exp_a = AB'(i * 16);
            n_checks++;
            if (rd_valid !== 1'b1 || rd_addr !== exp_a) begin
                n_fail++;
                $display("FAIL order_head%0d got v=%0b a=%h want 1/%h",
                         i, rd_valid, rd_addr, exp_a);
            end
            n_checks++;
            if (head_act() !== mq[0]) begin
                n_fail++;
                $display("FAIL order_rec%0d got %h want %h", i, head_act(), mq[0]);
            end
            drive_cycle(0, '0, 1, 0, 0, 0);
        end
        n_checks++;
        if (rd_valid !== 1'b0 || err_count !== 4'd3) begin
            n_fail++;
            $display("FAIL order_end got v=%0b cnt=%0d want 0/3",
                     rd_valid, err_count);
        end
    endtask

    task automatic test_overflow();
        logic [AB-1:0] exp_a;
        drive_cycle(0, '0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1, AB'(32'h1000 + i), 0, 0, 0, 0);
            if (i == 7) begin
                n_checks++;
                if (overflow !== 1'b0) begin
                    n_fail++; $display("FAIL ovf_at_full got %0b want 0", overflow);
                end
            end
        end
        n_checks++;
        if (overflow !== 1'b1 || err_count !== 4'd10) begin
            n_fail++;
            $display("FAIL ovf_flag got ovf=%0b cnt=%0d want 1/10",
                     overflow, err_count);
        end
        for (int i = 0; i < 8; i++) begin
            exp_a = AB'(32'h1000 + i);
            n_checks++;
            if (rd_valid !== 1'b1 || rd_addr !== exp_a || head_act() !== mq[0]) begin
                n_fail++;
                $display("FAIL ovf_read%0d got v=%0b a=%h want 1/%h",
                         i, rd_valid, rd_addr, exp_a);
            end
            drive_cycle(0, '0, 1, 0, 0, 0);
        end
        n_checks++;
        if (rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL ovf_drained got %0b want 0", rd_valid);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        for (int fill = 1; fill <= DEP; fill += DEP - 1) begin
            drive_cycle(0, '0, 0, 0, 0, 1);
            for (int i = 0; i < fill; i++)
                drive_cycle(1, AB'($urandom), 0, 0, 0, 0);
            for (int i = 0; i < 4; i++) begin
                drive_cycle(1, AB'($urandom), 1, 0, 0, 0);
                n_checks++;
                if (rd_valid !== 1'b1 || overflow !== 1'b0 ||
                    head_act() !== mq[0]) begin
                    n_fail++;
                    $display("FAIL b2b_f%0d_c%0d got v=%0b ovf=%0b head=%h want 1/0/%h",
                             fill, i, rd_valid, overflow, head_act(), mq[0]);
                end
            end
            n = 0;
            while (rd_valid === 1'b1 && n < 20) begin
                n_checks++;
                if (mq.size() == 0 || head_act() !== mq[0]) begin
                    n_fail++;
                    $display("FAIL b2b_drain%0d got %h want model head", n, head_act());
                end
                drive_cycle(0, '0, 1, 0, 0, 0);
                n++;
            end
            n_checks++;
            if (n != fill) begin
                n_fail++;
                $display("FAIL b2b_occupancy got %0d want %0d", n, fill);
            end
        end
    endtask

    task automatic test_rounds();
        drive_cycle(0, '0, 0, 0, 0, 1);
        drive_cycle(0, '0, 0, 1, 1, 0);
        n_checks++;
        if (status !== 2'd1) begin
            n_fail++; $display("FAIL rounds_passing got %0d want 1", status);
        end
        repeat (4) drive_cycle(0, '0, 0, 1, 1, 0);
        drive_cycle(1, AB'($urandom), 1, 1, 1, 0);
        n_checks++;
        if (round_count !== 4'd6 || fail_rounds !== 4'd1 || status !== 2'd2) begin
            n_fail++;
            $display("FAIL rounds_fail got rc=%0d fr=%0d st=%0d want 6/1/2",
                     round_count, fail_rounds, status);
        end
        drive_cycle(1, AB'($urandom), 1, 0, 0, 0);
        drive_cycle(0, '0, 1, 1, 1, 0);
        drive_cycle(0, '0, 1, 1, 1, 0);
        n_checks++;
        if (fail_rounds !== 4'd2 || round_count !== 4'd8 || status !== 2'd2) begin
            n_fail++;
            $display("FAIL rounds_sticky got rc=%0d fr=%0d st=%0d want 8/2/2",
                     round_count, fail_rounds, status);
        end
    endtask

    task automatic test_saturation();
        drive_cycle(0, '0, 0, 0, 0, 1);
        repeat (20) drive_cycle(0, '0, 0, 1, 1, 0);
        n_checks++;
        if (round_count !== 4'd15 || fail_rounds !== 4'd0 || status !== 2'd1) begin
            n_fail++;
            $display("FAIL sat_rounds got rc=%0d fr=%0d st=%0d want 15/0/1",
                     round_count, fail_rounds, status);
        end
        repeat (20) drive_cycle(1, AB'($urandom), 1, 0, 0, 0);
        n_checks++;
        if (err_count !== 4'd15 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_errs got cnt=%0d ovf=%0b want 15/0",
                     err_count, overflow);
        end
    endtask

    task automatic test_clear();
        repeat (3) drive_cycle(1, AB'($urandom), 0, 0, 0, 0);
        drive_cycle(0, '0, 0, 1, 0, 0);
        drive_cycle(1, AB'($urandom), 0, 1, 1, 1);
        n_checks++;
        if ({round_count, fail_rounds, err_count} !== '0 || rd_valid !== 1'b0 ||
            overflow !== 1'b0 || status !== 2'd0) begin
            n_fail++;
            $display("FAIL clear_all got rc=%0d fr=%0d ec=%0d v=%0b ovf=%0b st=%0d want 0",
                     round_count, fail_rounds, err_count, rd_valid, overflow, status);
        end
        drive_cycle(0, '0, 0, 1, 1, 0);
        n_checks++;
        if (status !== 2'd1 || fail_rounds !== 4'd0) begin
            n_fail++;
            $display("FAIL clear_round_err got st=%0d fr=%0d want 1/0",
                     status, fail_rounds);
        end
    endtask

    task automatic test_async_reset();
        repeat (2) drive_cycle(1, AB'($urandom), 0, 0, 0, 0);
        drive_cycle(0, '0, 0, 1, 0, 0);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if (rd_valid !== 1'b0 || head_act() !== '0 || overflow !== 1'b0 ||
            {round_count, fail_rounds, err_count} !== '0 || status !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset got v=%0b rc=%0d fr=%0d ec=%0d st=%0d want 0",
                     rd_valid, round_count, fail_rounds, err_count, status);
        end
        @(negedge clk) reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        drive_cycle(0, '0, 0, 0, 0, 1);
        for (int c = 0; c < 400; c++) begin
            drive_cycle($urandom_range(0, 99) < 45, AB'($urandom),
                        $urandom_range(0, 99) < 40,
                        $urandom_range(0, 99) < 8,
                        $urandom_range(0, 99) < 80,
                        $urandom_range(0, 99) < 2);
            n_checks++;
            if (rd_valid !== (mq.size() > 0)) begin
                n_fail++;
                $display("FAIL rnd_valid c%0d got %0b want %0b",
                         c, rd_valid, mq.size() > 0);
            end
            if (mq.size() > 0) begin
                n_checks++;
                if (head_act() !== mq[0]) begin
                    n_fail++;
                    $display("FAIL rnd_head c%0d got %h want %h", c, head_act(), mq[0]);
                end
            end
            n_checks++;
            if (round_count !== CB'(m_round) || fail_rounds !== CB'(m_fail) ||
                err_count !== CB'(m_err)) begin
                n_fail++;
                $display("FAIL rnd_counters c%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                         c, round_count, fail_rounds, err_count,
                         m_round, m_fail, m_err);
            end
            n_checks++;
            if (overflow !== m_ovf || status !== 2'(m_st)) begin
                n_fail++;
                $display("FAIL rnd_status c%0d got ovf=%0b st=%0d want %0b/%0d",
                         c, overflow, status, m_ovf, m_st);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fifo_order();
        test_overflow();
        test_back_to_back();
        test_rounds();
        test_saturation();
        test_clear();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
